mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer in front of the memory/IO bus controller. Port 0 (CPU) and port 1 (boot loader/DMA) each issue single req/ack transfers. The block serialises them onto the controller's CPU-side bus (addr, write data, we, re, be) and inserts a wait-state count per transfer: RAM_WAIT below UART_BASE, UART_WAIT at or above it. It holds bus signals stable for the whole access, captures read data and returns a one-cycle ack to the owner.

## Interface
- RAM_WAIT, 0: extra ACCESS cycles for addresses < UART_BASE.
- UART_WAIT, 2: extra ACCESS cycles for addresses >= UART_BASE.
- UART_BASE, 16'h0ff0: first address decoded as UART space (unsigned compare).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- m0_req, m1_req  in  1  transfer request, held high until ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_be, m1_be  in  1  byte access (passed to bus be).
- m0_addr, m1_addr  in  16  byte address.
- m0_wdata, m1_wdata  in  16  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  16  read data, valid from the ack cycle until the next ack to that port.
- bus_addr  out  16  to controller CPUaddr.
- bus_wdata  out  16  to controller CPUwrite.
- bus_we, bus_re, bus_be  out  1  to controller we/re/be.
- bus_rdata  in  16  from controller CPUread.
- bus_owner  out  1  port currently or last granted.

## Operation
- FSM states IDLE, ACCESS, RESP.
- **IDLE:**
  - If no req, stay in IDLE.
  - Otherwise pick a winner and latch its addr, wdata, we and be.
  - Load cnt = (addr >= UART_BASE) ? UART_WAIT : RAM_WAIT and go to ACCESS.
- **ACCESS:**
  - bus_addr, bus_wdata and bus_be driven from latched values.
  - bus_re = ~we for every ACCESS cycle.
  - bus_we = we only in the first ACCESS cycle, so UART registers see exactly one write strobe.
  - When cnt == 0, capture bus_rdata into the owner's rdata (reads only; writes leave rdata unchanged) and go to RESP. Otherwise decrement cnt.
- **RESP:** owner's ack = 1 for this cycle only; then go to IDLE.
- req is sampled only in IDLE. Changes to req, addr or wdata during ACCESS or RESP are ignored.
- A requester drops req on the edge after it sees ack. A req still high in IDLE is a new transfer.
- cnt is wide enough for max(RAM_WAIT, UART_WAIT); no wrap.
- Arbitration with simultaneous requests is selected by the Configuration macro. A single requester always wins immediately.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; any in-flight transfer is abandoned with no ack.
  - All outputs are 0: acks, rdata, bus_* and bus_owner.
  - cnt = 0; round-robin pointer = 1.

## Timing
- req high in IDLE at cycle 0 → ACCESS for cycles 1 … W+1 → RESP (ack) at cycle W+2, where W is the wait value loaded.
- RAM with RAM_WAIT=0: ack 2 cycles after req is sampled.
- UART with UART_WAIT=2: ack 4 cycles after req is sampled.
- Back-to-back: minimum of one IDLE cycle between transfers, so RAM_WAIT=0 throughput is one transfer per 3 cycles.
- bus_re falls and bus_addr holds its value in RESP and IDLE.
- Outside ACCESS, bus_we and bus_re are always 0.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, grant the port that was not granted last.
  - The pointer updates on each grant and resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority; port 0 always wins ties and the pointer logic is absent.
- Single-requester behaviour is identical in both builds.

## Test plan
- m0 read addr 16'h0010, bus_rdata=16'hBEEF, RAM_WAIT=0 → bus_re high cycles 1, bus_we never high, m0_ack at cycle 2, m0_rdata=16'hBEEF.
- m1 write addr 16'h0ff3 data 16'h0041, UART_WAIT=2 → bus_we high exactly 1 cycle, bus_addr=16'h0ff3 for cycles 1–3, m1_ack at cycle 4, m1_rdata unchanged.
- m0_req and m1_req both held high continuously:
  - With ARB_ROUND_ROBIN_EN: acks alternate m0, m1, m0, m1.
  - Without it: only m0 is acked while m0_req stays high.
- m0 byte write be=1 addr 16'h0021 → bus_be=1 for the full ACCESS; m0_addr changed to 16'h0000 mid-ACCESS → bus_addr stays 16'h0021.
- reset pulsed in the second ACCESS cycle of a UART read:
  - All outputs 0 immediately, no ack.
  - After release with m1_req high, a fresh transfer completes normally.
- m0 holds req one extra cycle after ack → second transfer to the same address starts; its ack arrives W+3 cycles after the first ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port req/ack arbiter and wait-state sequencer for the memory/IO bus
// Tie-break policy: ARB_ROUND_ROBIN_EN selects round-robin, otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int          RAM_WAIT  = 0,
    parameter int          UART_WAIT = 2,
    parameter logic [15:0] UART_BASE = 16'h0ff0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_be,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_be,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    output logic        bus_be,
    input  logic [15:0] bus_rdata,
    output logic        bus_owner
);

    localparam int MAXW = (RAM_WAIT > UART_WAIT) ? RAM_WAIT : UART_WAIT;
    localparam int CW   = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          lat_we;
    logic          lat_be;
    logic          first;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_wdata;

    logic          any_req;
    logic          win;
    logic [15:0]   win_addr;
    logic [15:0]   win_wdata;
    logic          win_we;
    logic          win_be;

    assign any_req = m0_req | m1_req;

`ifdef ARB_ROUND_ROBIN_EN
    // last holds the most recent grant; reset to 1 so port 0 wins the first tie
    logic last;

    always_comb begin
        win = ~m0_req;
        if (m0_req && m1_req) begin
            win = ~last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last <= win;
        end
    end
`else
    always_comb begin
        win = ~m0_req;
    end
`endif

    always_comb begin
        win_addr  = win ? m1_addr  : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
        win_we    = win ? m1_we    : m0_we;
        win_be    = win ? m1_be    : m0_be;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_be    <= 1'b0;
            first     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= win;
                        lat_addr  <= win_addr;
                        lat_wdata <= win_wdata;
                        lat_we    <= win_we;
                        lat_be    <= win_be;
                        first     <= 1'b1;
                        cnt       <= (win_addr >= UART_BASE) ? CW'(UART_WAIT) : CW'(RAM_WAIT);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    first <= 1'b0;
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (owner) begin
                                m1_rdata <= bus_rdata;
                            end else begin
                                m0_rdata <= bus_rdata;
                            end
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // write strobe only on the first access cycle so UART registers see one write
    assign bus_we    = (state == ACCESS) && lat_we && first;
    assign bus_re    = (state == ACCESS) && !lat_we;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;
    assign bus_be    = lat_be;
    assign bus_owner = owner;
    assign m0_ack    = (state == RESP) && !owner;
    assign m1_ack    = (state == RESP) && owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-schedule model
module tb_mem_arbiter;

    localparam logic [15:0] UB = 16'h0ff0;
    localparam int RW = 0;
    localparam int UW = 2;
    localparam int NC = 800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq[2];
    logic        we_i[2];
    logic        be_i[2];
    logic [15:0] ad[2];
    logic [15:0] wd[2];
    logic [15:0] bus_rdata = '0;
    logic        m0_ack, m1_ack, bus_we, bus_re, bus_be, bus_owner;
    logic [15:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;

    mem_arbiter #(.RAM_WAIT(RW), .UART_WAIT(UW), .UART_BASE(UB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(rq[0]), .m0_we(we_i[0]), .m0_be(be_i[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(rq[1]), .m1_we(we_i[1]), .m1_be(be_i[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"}, m0_ack, 0);
        check({tag, "_ack1"}, m1_ack, 0);
        check({tag, "_rd0"}, m0_rdata, 0);
        check({tag, "_rd1"}, m1_rdata, 0);
        check({tag, "_addr"}, bus_addr, 0);
        check({tag, "_wdata"}, bus_wdata, 0);
        check({tag, "_we"}, bus_we, 0);
        check({tag, "_re"}, bus_re, 0);
        check({tag, "_be"}, bus_be, 0);
        check({tag, "_owner"}, bus_owner, 0);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom % 4)
            0: return UB - 16'd1;
            1: return UB;
            2: return 16'($urandom_range(0, 32'h0fef));
            default: return 16'($urandom_range(32'h0ff0, 32'hffff));
        endcase
    endfunction

    // reference model: one active transfer described by its grant cycle and wait count
    bit          act;
    int          s_cyc, w;
    bit          t_own, t_we, t_be;
    logic [15:0] t_addr, t_wdata;
    logic [15:0] m_rd[2];
    bit          m_owner, m_last;
    logic [15:0] rlog[NC];
    bit          ackd[2];
    bit          did_rst;

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; we_i[p] = 0; be_i[p] = 0; ad[p] = '0; wd[p] = '0;
            m_rd[p] = '0; ackd[p] = 0;
        end
        act = 0; s_cyc = 0; w = 0; t_own = 0; t_we = 0; t_be = 0;
        t_addr = '0; t_wdata = '0; m_owner = 0; m_last = 1; did_rst = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #2 reset = 0;

        for (int c = 0; c < NC; c++) begin
            bit idle, acc, resp;
            bit e_ack[2];
            @(posedge clk);
            #1;
            cyc = c;
            for (int p = 0; p < 2; p++) begin
                if (rq[p]) begin
                    if (ackd[p] && ($urandom % 4 != 0)) rq[p] = 0;
                end else if ($urandom % 3 == 0) begin
                    rq[p] = 1;
                    we_i[p] = 1'($urandom);
                    be_i[p] = 1'($urandom);
                    ad[p] = rand_addr();
                    wd[p] = 16'($urandom);
                end
                if ($urandom % 4 == 0) begin
                    ad[p] = rand_addr();
                    wd[p] = 16'($urandom);
                end
            end
            bus_rdata = 16'($urandom);
            rlog[c] = bus_rdata;

            idle = !act;
            acc  = act && c >= s_cyc + 1 && c <= s_cyc + w + 1;
            resp = act && c == s_cyc + w + 2;
            e_ack[0] = 0;
            e_ack[1] = 0;
            if (resp) begin
                e_ack[t_own] = 1;
                if (!t_we) m_rd[t_own] = rlog[c-1];
            end

            @(negedge clk);
            check("ack0", m0_ack, e_ack[0]);
            check("ack1", m1_ack, e_ack[1]);
            check("rdata0", m0_rdata, m_rd[0]);
            check("rdata1", m1_rdata, m_rd[1]);
            check("bus_re", bus_re, acc && !t_we);
            check("bus_we", bus_we, acc && t_we && c == s_cyc + 1);
            check("bus_addr", bus_addr, t_addr);
            check("bus_owner", bus_owner, m_owner);
            if (acc) begin
                check("bus_wdata", bus_wdata, t_wdata);
                check("bus_be", bus_be, t_be);
            end

            ackd[0] = e_ack[0];
            ackd[1] = e_ack[1];
            if (resp) act = 0;

            // abandon a UART read in its second access cycle
            if (!did_rst && c > 50 && acc && c == s_cyc + 2 && w == UW && !t_we) begin
                #2 reset = 1;
                #1;
                check_all_zero("midrst");
                reset = 0;
                did_rst = 1;
                act = 0; idle = 1;
                m_owner = 0; m_last = 1;
                m_rd[0] = '0; m_rd[1] = '0;
                t_addr = '0; t_wdata = '0; t_be = 0; t_we = 0;
                ackd[0] = 0; ackd[1] = 0;
            end

            if (idle && (rq[0] || rq[1])) begin
                bit win;
                if (rq[0] && rq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = !m_last;
`else
                    win = 0;
`endif
                end else begin
                    win = rq[1];
                end
                m_last  = win;
                m_owner = win;
                act     = 1;
                s_cyc   = c;
                t_own   = win;
                t_we    = we_i[win];
                t_be    = be_i[win];
                t_addr  = ad[win];
                t_wdata = wd[win];
                w       = (ad[win] >= UB) ? UW : RW;
            end
        end

        check("reset_exercised", 32'(did_rst), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
